// File: rtl/mem_access_seq_if.sv
// Request, memory and merge-unit signals of the memory-access sequencer.
// The sequencer takes the slave view; whatever drives requests and models memory takes the master view.
interface mem_access_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] ls_out;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mdr;
  logic [2:0]  ls_ctrl;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic        err;

  modport slave (
    input  start, op, addr, ls_out, mem_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata, mdr, ls_ctrl, busy, done, wb_en, err
  );

  modport master (
    output start, op, addr, ls_out, mem_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, mdr, ls_ctrl, busy, done, wb_en, err
  );
endinterface

// File: rtl/mem_access_seq.sv
// Multicycle memory-access sequencer: owns the MDR, issues reads/writes with a fixed read
// latency and steps the load/store merge unit through loads, stores and read-modify-writes.
module mem_access_seq #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  mem_access_seq_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StLs, StWrite, StDone} state_e;

  localparam logic [3:0] LatLoad = 4'(MEM_LATENCY - 1);

  localparam logic [2:0] OpLw = 3'b001;
  localparam logic [2:0] OpLh = 3'b010;
  localparam logic [2:0] OpLb = 3'b011;
  localparam logic [2:0] OpSw = 3'b100;
  localparam logic [2:0] OpSh = 3'b101;
  localparam logic [2:0] OpSb = 3'b110;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mdr_q, mdr_d;
  logic        err_q, err_d;

  logic        req_ok;
  logic        op_q_load;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata;
  logic [2:0]  ls_ctrl;
  logic        done, wb_en, err;

  // Alignment is judged on the raw request, before anything is latched.
  always_comb begin
    case (bus.op)
      OpLw, OpSw: req_ok = (bus.addr[1:0] == 2'b00);
      OpLh, OpSh: req_ok = ~bus.addr[0];
      OpLb, OpSb: req_ok = 1'b1;
      default:    req_ok = 1'b0;
    endcase
  end

  assign op_q_load = (op_q == OpLw) || (op_q == OpLh) || (op_q == OpLb);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    mdr_d     = mdr_q;
    err_d     = err_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 32'h0;
    ls_ctrl   = 3'b000;
    done      = 1'b0;
    wb_en     = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d   = bus.op;
          addr_d = bus.addr;
          err_d  = ~req_ok;
          if (!req_ok) begin
            state_d = StDone;
          end else if (bus.op == OpSw) begin
            state_d = StLs;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        mem_rd  = 1'b1;
        cnt_d   = LatLoad;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          mdr_d   = bus.mem_rdata;
          state_d = StLs;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StLs: begin
        ls_ctrl = op_q;
        state_d = op_q_load ? StDone : StWrite;
      end
      StWrite: begin
        // Control stays on op_q so the merged word is still on ls_out here.
        ls_ctrl   = op_q;
        mem_wr    = 1'b1;
        mem_wdata = bus.ls_out;
        state_d   = StDone;
      end
      StDone: begin
        ls_ctrl = op_q;
        done    = 1'b1;
        err     = err_q;
        wb_en   = op_q_load & ~err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      cnt_q   <= 4'd0;
      mdr_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mdr       = mdr_q;
  assign bus.ls_ctrl   = ls_ctrl;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done;
  assign bus.wb_en     = wb_en;
  assign bus.err       = err;

  a_rd_wr_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_rd && bus.mem_wr));

  a_done_single : assert property (@(posedge clk) disable iff (reset)
    bus.done |=> !bus.done);

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two instances (latency 1 and 3) share stimulus; a memory model and a
// merge-unit stub close the loop, and results are compared against timing/data rules.
module tb_mem_access_seq;

  typedef struct {
    int          cyc;
    int          n_rd;
    int          rd_cyc;
    logic [31:0] rd_addr;
    int          n_wr;
    int          wr_cyc;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    int          n_done;
    int          done_cyc;
    logic        err;
    logic        wb_en;
    logic [31:0] ls_out;
    logic [31:0] mdr_done;
    logic [31:0] mdr_now;
    logic        nz_now;
    int          busy_cnt;
    int          ctrl_cnt;
    logic [2:0]  ctrl_val;
    int          bad;
  } mon_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] b;
    logic [31:0] word;
    logic        err;
    logic [31:0] res;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [1:0]  start_v;
  logic [2:0]  op_in;
  logic [31:0] addr_in;
  logic [31:0] b_in;
  logic        mon_clr;
  logic [31:0] mem [64];

  int          n_cmp;
  int          n_bad;
  mon_t        res [2];
  logic [31:0] mdr_model [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural merge unit (big-endian lanes, sign-extending sub-word loads).
  function automatic logic [31:0] merge(logic [2:0] c, logic [31:0] m, logic [31:0] b,
                                        logic [1:0] a);
    logic [31:0] r;
    logic [15:0] h;
    logic [7:0]  by;
    int          sh;
    sh = 8 * (3 - int'(a));
    r  = 32'h0;
    case (c)
      3'd1: r = m;
      3'd2: begin
        h = a[1] ? m[15:0] : m[31:16];
        r = {{16{h[15]}}, h};
      end
      3'd3: begin
        by = m[sh +: 8];
        r  = {{24{by[7]}}, by};
      end
      3'd4: r = b;
      3'd5: r = a[1] ? {m[31:16], b[15:0]} : {b[15:0], m[15:0]};
      3'd6: begin
        r = m;
        r[sh +: 8] = b[7:0];
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic illegal(logic [2:0] op, logic [31:0] addr);
    case (op)
      3'd1, 3'd4: return addr[1:0] != 2'b00;
      3'd2, 3'd5: return addr[0];
      3'd3, 3'd6: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned L = (g == 0) ? 1 : 3;

    mem_access_seq_if bus ();
    mon_t        m;
    logic [31:0] ls_out_r;
    logic [15:0] pv;
    logic [31:0] pa [16];

    assign bus.start     = start_v[g];
    assign bus.op        = op_in;
    assign bus.addr      = addr_in;
    assign bus.ls_out    = ls_out_r;
    assign bus.mem_rdata = pv[L-1] ? mem[pa[L-1][7:2]] : 32'h0BAD_F00D;

    mem_access_seq #(.MEM_LATENCY(L)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    always @(posedge clk) begin
      ls_out_r <= reset ? 32'h0 : merge(bus.ls_ctrl, bus.mdr, b_in, addr_in[1:0]);
      pv       <= {pv[14:0], bus.mem_rd};
      pa[0]    <= bus.mem_addr;
      for (int i = 1; i < 16; i++) pa[i] <= pa[i-1];
    end

    always @(negedge clk) begin
      m.mdr_now <= bus.mdr;
      m.nz_now  <= (|bus.mem_addr) | bus.mem_rd | bus.mem_wr | (|bus.mem_wdata) | (|bus.mdr) |
                   (|bus.ls_ctrl) | bus.busy | bus.done | bus.wb_en | bus.err;
      if (mon_clr) begin
        m.cyc      <= 0;
        m.n_rd     <= 0;
        m.n_wr     <= 0;
        m.n_done   <= 0;
        m.busy_cnt <= 0;
        m.ctrl_cnt <= 0;
        m.bad      <= 0;
      end else begin
        m.cyc <= m.cyc + 1;
        if (bus.mem_rd) begin
          m.n_rd    <= m.n_rd + 1;
          m.rd_cyc  <= m.cyc + 1;
          m.rd_addr <= bus.mem_addr;
        end
        if (bus.mem_wr) begin
          m.n_wr    <= m.n_wr + 1;
          m.wr_cyc  <= m.cyc + 1;
          m.wr_addr <= bus.mem_addr;
          m.wr_data <= bus.mem_wdata;
        end
        if (bus.done) begin
          m.n_done   <= m.n_done + 1;
          m.done_cyc <= m.cyc + 1;
          m.err      <= bus.err;
          m.wb_en    <= bus.wb_en;
          m.ls_out   <= bus.ls_out;
          m.mdr_done <= bus.mdr;
        end
        if (bus.busy) m.busy_cnt <= m.busy_cnt + 1;
        if (bus.ls_ctrl != 3'b000) begin
          m.ctrl_cnt <= m.ctrl_cnt + 1;
          m.ctrl_val <= bus.ls_ctrl;
        end
        if ((bus.mem_rd && bus.mem_wr) || (!bus.mem_wr && bus.mem_wdata != 32'h0))
          m.bad <= m.bad + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    res[0] = g_inst[0].m;
    res[1] = g_inst[1].m;
  endtask

  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat=%0d got %h want %h", nm, (g == 0) ? 1 : 3, act, exp);
    end
  endtask

  task automatic run_op(logic [2:0] op, logic [31:0] addr, logic [31:0] b, logic exp_err,
                        logic [31:0] exp_res);
    logic [31:0] mw;
    logic        ld, st, rd, wr;
    int          lat, n;
    mw = mem[addr[7:2]];
    step();
    start_v = 2'b11; op_in = op; addr_in = addr; b_in = b; mon_clr = 1'b1;
    step();
    start_v = 2'b00; mon_clr = 1'b0;
    repeat (10) step();
    snap();
    ld = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
    st = (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
    rd = !exp_err && (ld || op == 3'd5 || op == 3'd6);
    wr = !exp_err && st;
    for (int g = 0; g < 2; g++) begin
      lat = (g == 0) ? 1 : 3;
      n = exp_err ? 1 : (op == 3'd4) ? 3 : ld ? 3 + lat : 4 + lat;
      chk("done_count", g, res[g].n_done, 1);
      chk("done_cycle", g, res[g].done_cyc, n);
      chk("err", g, 32'(res[g].err), 32'(exp_err));
      chk("wb_en", g, 32'(res[g].wb_en), 32'(ld && !exp_err));
      chk("busy_cycles", g, res[g].busy_cnt, n);
      chk("rd_count", g, res[g].n_rd, 32'(rd));
      chk("wr_count", g, res[g].n_wr, 32'(wr));
      if (rd) begin
        chk("rd_cycle", g, res[g].rd_cyc, 1);
        chk("rd_addr", g, res[g].rd_addr, {addr[31:2], 2'b00});
        mdr_model[g] = mw;
      end
      if (wr) begin
        chk("wr_cycle", g, res[g].wr_cyc, n - 1);
        chk("wr_addr", g, res[g].wr_addr, {addr[31:2], 2'b00});
        chk("wr_data", g, res[g].wr_data, exp_res);
      end
      if (ld && !exp_err) chk("load_result", g, res[g].ls_out, exp_res);
      if (!exp_err) begin
        chk("ctrl_cycles", g, res[g].ctrl_cnt, ld ? 2 : 3);
        chk("ctrl_value", g, 32'(res[g].ctrl_val), 32'(op));
      end
      chk("mdr_at_done", g, res[g].mdr_done, mdr_model[g]);
      chk("mdr_after", g, res[g].mdr_now, mdr_model[g]);
      chk("bus_rules", g, res[g].bad, 0);
    end
    if (wr) mem[addr[7:2]] = exp_res;
  endtask

  initial begin
    vec_t        tbl [15];
    logic [2:0]  rop;
    logic [31:0] raddr, rb, rres;
    logic        re;

    tbl[0]  = '{3'd1, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    tbl[1]  = '{3'd6, 32'h43, 32'hAA,       32'h11223344, 1'b0, 32'h112233AA};
    tbl[2]  = '{3'd4, 32'h10, 32'hCAFEF00D, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[3]  = '{3'd2, 32'h21, 32'h0,        32'h77777777, 1'b1, 32'h0};
    tbl[4]  = '{3'd7, 32'h44, 32'h0,        32'h88888888, 1'b1, 32'h0};
    tbl[5]  = '{3'd2, 32'h22, 32'h0,        32'h12348765, 1'b0, 32'hFFFF8765};
    tbl[6]  = '{3'd3, 32'h45, 32'h0,        32'hA1B2C3D4, 1'b0, 32'hFFFFFFB2};
    tbl[7]  = '{3'd5, 32'h4A, 32'h0000BEEF, 32'h55667788, 1'b0, 32'h5566BEEF};
    tbl[8]  = '{3'd0, 32'h00, 32'h0,        32'h1,        1'b1, 32'h0};
    tbl[9]  = '{3'd4, 32'h12, 32'h1,        32'h2,        1'b1, 32'h0};
    tbl[10] = '{3'd5, 32'h31, 32'h1,        32'h3,        1'b1, 32'h0};
    tbl[11] = '{3'd3, 32'h07, 32'h0,        32'h01020304, 1'b0, 32'h00000004};
    tbl[12] = '{3'd6, 32'h50, 32'h12,       32'hFFFFFFFF, 1'b0, 32'h12FFFFFF};
    tbl[13] = '{3'd1, 32'h42, 32'h0,        32'h5,        1'b1, 32'h0};
    tbl[14] = '{3'd3, 32'h04, 32'h0,        32'h80000000, 1'b0, 32'hFFFFFF80};

    n_cmp = 0; n_bad = 0;
    reset = 1'b1; start_v = 2'b00; op_in = 3'd0; addr_in = 32'h0; b_in = 32'h0; mon_clr = 1'b1;
    mdr_model[0] = 32'h0; mdr_model[1] = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h3C00_0000 + 32'(i);

    // Reset state.
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk); #1;
    snap();
    for (int g = 0; g < 2; g++) begin
      chk("reset_outputs", g, 32'(res[g].nz_now), 0);
      chk("reset_mdr", g, res[g].mdr_now, 32'h0);
    end

    foreach (tbl[i]) begin
      mem[tbl[i].addr[7:2]] = tbl[i].word;
      run_op(tbl[i].op, tbl[i].addr, tbl[i].b, tbl[i].err, tbl[i].res);
    end

    // Reset asserted during WAIT of a read-modify-write.
    mem[24] = 32'h0A0B0C0D;
    step();
    start_v = 2'b11; op_in = 3'd5; addr_in = 32'h62; b_in = 32'h1234; mon_clr = 1'b1;
    step();
    start_v = 2'b00; mon_clr = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk); #1;
    snap();
    for (int g = 0; g < 2; g++) chk("reset_mid_idle", g, 32'(res[g].nz_now), 0);
    repeat (10) step();
    snap();
    for (int g = 0; g < 2; g++) begin
      chk("reset_mid_no_wr", g, res[g].n_wr, 0);
      chk("reset_mid_no_done", g, res[g].n_done, 0);
      chk("reset_mid_busy", g, res[g].busy_cnt, 2);
      mdr_model[g] = 32'h0;
    end
    run_op(3'd1, 32'h60, 32'h0, 1'b0, 32'h0A0B0C0D);

    // Reset together with start drops the request.
    step();
    start_v = 2'b11; op_in = 3'd1; addr_in = 32'h40; reset = 1'b1; mon_clr = 1'b1;
    step();
    start_v = 2'b00; reset = 1'b0; mon_clr = 1'b0;
    @(negedge clk); #1;
    snap();
    for (int g = 0; g < 2; g++) chk("reset_start_idle", g, 32'(res[g].nz_now), 0);
    repeat (10) step();
    snap();
    for (int g = 0; g < 2; g++) begin
      chk("reset_start_no_done", g, res[g].n_done, 0);
      chk("reset_start_no_rd", g, res[g].n_rd, 0);
      mdr_model[g] = 32'h0;
    end

    // start pulsed during LS (cycle 3 for latency 1, cycle 5 for latency 3) is ignored.
    mem[16] = 32'h600DCAFE;
    step();
    start_v = 2'b11; op_in = 3'd1; addr_in = 32'h40; mon_clr = 1'b1;
    step();
    start_v = 2'b00; mon_clr = 1'b0;
    step();
    step(); start_v = 2'b01;
    step(); start_v = 2'b00;
    step(); start_v = 2'b10;
    step(); start_v = 2'b00;
    repeat (8) step();
    snap();
    for (int g = 0; g < 2; g++) begin
      chk("busy_start_done_count", g, res[g].n_done, 1);
      chk("busy_start_done_cycle", g, res[g].done_cyc, (g == 0) ? 4 : 6);
      chk("busy_start_rd_count", g, res[g].n_rd, 1);
      chk("busy_start_result", g, res[g].ls_out, 32'h600DCAFE);
      mdr_model[g] = 32'h600DCAFE;
    end

    // start held through DONE: a second sw is accepted in the following IDLE cycle.
    step();
    start_v = 2'b11; op_in = 3'd4; addr_in = 32'h20; b_in = 32'h55AA55AA; mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    repeat (4) step();
    start_v = 2'b00;
    repeat (8) step();
    snap();
    for (int g = 0; g < 2; g++) begin
      chk("held_start_done_count", g, res[g].n_done, 2);
      chk("held_start_last_done", g, res[g].done_cyc, 7);
      chk("held_start_wr_count", g, res[g].n_wr, 2);
      chk("held_start_wr_cycle", g, res[g].wr_cyc, 6);
      chk("held_start_wr_data", g, res[g].wr_data, 32'h55AA55AA);
    end
    mem[8] = 32'h55AA55AA;

    // Randomised requests against the rule-based model.
    for (int k = 0; k < 40; k++) begin
      rop   = 3'($urandom_range(0, 7));
      raddr = 32'($urandom_range(0, 255));
      rb    = $urandom;
      if ($urandom_range(0, 1) == 1) mem[raddr[7:2]] = $urandom;
      re    = illegal(rop, raddr);
      rres  = re ? 32'h0 : merge(rop, mem[raddr[7:2]], rb, raddr[1:0]);
      run_op(rop, raddr, rb, re, rres);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Multicycle memory-access sequencer that sits directly upstream of the load/store merge unit. It owns the memory data register (MDR), issues memory reads and writes, and drives the merge unit's 3-bit control. It sequences the unit's registered one-cycle output so that loads return a result and stores (including read-modify-write for halfword and byte) write the merged word back. Memory has a fixed read latency.

## Interface
- MEM_LATENCY, 1, cycles from the `mem_rd` cycle to valid `mem_rdata`; legal range 1..15.
- clk  in  1  single clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  merge-unit encoding: 001 lw, 010 lh, 011 lb, 100 sw, 101 sh, 110 sb.
- addr  in  32  byte address of the access.
- ls_out  in  32  registered output of the merge unit.
- mem_rdata  in  32  memory read data.
- mem_addr  out  32  word address `{addr_q[31:2],2'b00}`.
- mem_rd  out  1  read strobe, one cycle.
- mem_wr  out  1  write strobe, one cycle.
- mem_wdata  out  32  equals `ls_out` while `mem_wr` is high; 0 otherwise.
- mdr  out  32  memory data register; feeds the merge unit's MDR input.
- ls_ctrl  out  3  merge-unit control.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- wb_en  out  1  high with `done` for successful loads only; `ls_out` is the load result in that cycle.
- err  out  1  high with `done` for an illegal or misaligned request.

## Operation
- **Request capture.** In IDLE, `start=1` latches `op` and `addr` into `op_q` and `addr_q`. `start` is ignored in every other state.
- **Legality check**, performed on the `op`/`addr` inputs in the `start` cycle:
  - `op` of 000 or 111 is illegal.
  - lw/sw require `addr[1:0]==0`.
  - lh/sh require `addr[0]==0`.
  - lb/sb have no alignment requirement.
  - Failure → next state is DONE with `err=1`. No memory access occurs.
- **States:** IDLE, READ, WAIT, LS, WRITE, DONE.
- **Loads (lw/lh/lb):** IDLE→READ→WAIT(×MEM_LATENCY)→LS→DONE.
- **sw:** IDLE→LS→WRITE→DONE. No read is issued.
- **sh/sb (read-modify-write):** IDLE→READ→WAIT(×MEM_LATENCY)→LS→WRITE→DONE.
- **READ:** `mem_rd=1` and `mem_addr` valid for exactly one cycle. The 4-bit latency counter loads MEM_LATENCY-1.
- **WAIT:** the counter decrements each cycle. On the cycle it reads 0, `mdr <= mem_rdata` and the FSM leaves WAIT.
- **LS / WRITE / DONE:** `ls_ctrl = op_q`; it is 000 in all other states. This holds the merge unit's output stable through WRITE and DONE.
- **WRITE:** `mem_wr=1`, `mem_wdata=ls_out`, `mem_addr` valid.
- **DONE:** `done=1`. `wb_en=1` if `op_q` is a load and not an error. Next state is always IDLE.
- `mdr` changes only in the final WAIT cycle and on reset.
- `mem_rd` and `mem_wr` are never high in the same cycle.

## Timing
- `start` is sampled at edge 0. `done` is high in cycle N after edge 0:
  - error: N=1
  - sw: N=3
  - loads: N=3+MEM_LATENCY
  - sh/sb: N=4+MEM_LATENCY
- A new `start` is accepted no earlier than the cycle after DONE. There is no back-to-back overlap.
- **Reset values:** state IDLE; `mdr`, `addr_q`, `op_q`, counter, and all outputs 0; `ls_ctrl`=000.
- **Reset mid-operation:** the next cycle is IDLE with all outputs at reset values. Any pending `mem_wr` is suppressed and `done` is not pulsed.
- **Reset together with `start`:** reset wins and the request is dropped.

## Test plan
- **lw, MEM_LATENCY=1.** Stimulus: `start`, op=001, addr=0x40, `mem_rdata`=0xDEADBEEF in the cycle after `mem_rd`.
  - `mem_rd` in cycle 1 with `mem_addr`=0x40.
  - `mdr`=0xDEADBEEF from cycle 3.
  - `ls_ctrl`=001 in cycles 3–4.
  - `done` and `wb_en` in cycle 4; `ls_out`=0xDEADBEEF.
- **sb, MEM_LATENCY=3.** Stimulus: addr=0x43, memory word 0x11223344, B=0x000000AA.
  - `mem_rd` in cycle 1.
  - `mem_wr` in cycle 6 with `mem_wdata`=0x112233AA.
  - `done` in cycle 7; `wb_en`=0.
- **sw.** Stimulus: addr=0x10, B=0xCAFEF00D.
  - `mem_rd` never asserted.
  - `mem_wr` in cycle 2 with 0xCAFEF00D.
  - `done` in cycle 3.
- **Misaligned and illegal requests.** Stimulus: lh at addr=0x21, then op=111.
  - Each gives `done` and `err` in cycle 1.
  - No `mem_rd` or `mem_wr`; `mdr` unchanged.
- **Reset mid-sh.** Stimulus: assert reset in a WAIT cycle.
  - Next cycle: IDLE, `busy`=0, `mdr`=0.
  - No `mem_wr` and no `done` afterwards.
  - A subsequent lw completes normally.
- **`start` while busy.** Stimulus: pulse `start` during LS.
  - Ignored; exactly one `done`.
  - A `start` held high through DONE is accepted in the following IDLE cycle.
